// File: rtl/matbi_watch_set_ctrl.sv
// Time-set controller: sequences RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> LOAD -> RUN.
// Latency: all outputs registered; each reflects the state entered on the latest edge.
// Backpressure: none; button inputs are single-cycle pulses, consumed or ignored the cycle they arrive.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   i_mode/i_inc/i_dec/i_cancel button pulses (mode = enter SET / advance field)
//   i_cur_sec/min/hour          live time from the watch counters, sampled on SET entry
//   o_run_en                    run enable for the one-sec generator and tick counters
//   o_load                      one-cycle preset strobe carrying o_set_*
//   o_set_sec/min/hour          edited time
//   o_set_field                 0=none, 1=hour, 2=min, 3=sec (display blink select)
module matbi_watch_set_ctrl #(
    parameter int P_SEC_BIT     = 6,
    parameter int P_MIN_BIT     = 6,
    parameter int P_HOUR_BIT    = 5,
    parameter int P_TO_BIT      = 30,
    parameter int P_TIMEOUT_CYC = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_mode,
    input  logic                  i_inc,
    input  logic                  i_dec,
    input  logic                  i_cancel,
    input  logic [P_SEC_BIT-1:0]  i_cur_sec,
    input  logic [P_MIN_BIT-1:0]  i_cur_min,
    input  logic [P_HOUR_BIT-1:0] i_cur_hour,
    output logic                  o_run_en,
    output logic                  o_load,
    output logic [P_SEC_BIT-1:0]  o_set_sec,
    output logic [P_MIN_BIT-1:0]  o_set_min,
    output logic [P_HOUR_BIT-1:0] o_set_hour,
    output logic [1:0]            o_set_field
);

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_SET_HOUR = 3'd1,
        ST_SET_MIN  = 3'd2,
        ST_SET_SEC  = 3'd3,
        ST_LOAD     = 3'd4
    } state_t;

    localparam logic [P_SEC_BIT-1:0]  SEC_MAX  = P_SEC_BIT'(59);
    localparam logic [P_SEC_BIT-1:0]  SEC_ONE  = P_SEC_BIT'(1);
    localparam logic [P_MIN_BIT-1:0]  MIN_MAX  = P_MIN_BIT'(59);
    localparam logic [P_MIN_BIT-1:0]  MIN_ONE  = P_MIN_BIT'(1);
    localparam logic [P_HOUR_BIT-1:0] HOUR_MAX = P_HOUR_BIT'(23);
    localparam logic [P_HOUR_BIT-1:0] HOUR_ONE = P_HOUR_BIT'(1);
    localparam logic [P_TO_BIT-1:0]   TO_ONE   = P_TO_BIT'(1);
    localparam bit                    TO_EN    = (P_TIMEOUT_CYC > 0);
    // Only meaningful when TO_EN; with the timeout disabled the value is never compared.
    localparam logic [P_TO_BIT-1:0]   TO_LAST  = P_TO_BIT'(P_TIMEOUT_CYC - 1);

    state_t                  state_q, state_d;
    logic [P_SEC_BIT-1:0]    sec_q, sec_d;
    logic [P_MIN_BIT-1:0]    min_q, min_d;
    logic [P_HOUR_BIT-1:0]   hour_q, hour_d;
    logic [P_TO_BIT-1:0]     to_cnt_q, to_cnt_d;
    logic                    run_en_q, load_q;
    logic [1:0]              field_q, field_d;

    logic btn_any;
    logic do_inc;
    logic do_dec;
    logic in_set;

    assign btn_any = i_mode | i_inc | i_dec | i_cancel;
    // Simultaneous inc and dec cancel each other out.
    assign do_inc  = i_inc & ~i_dec;
    assign do_dec  = i_dec & ~i_inc;
    assign in_set  = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN) ||
                     (state_q == ST_SET_SEC);

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;

        unique case (state_q)
            ST_RUN: begin
                if (i_mode) begin
                    state_d = ST_SET_HOUR;
                    // Out-of-range live values start the edit from zero.
                    hour_d  = (i_cur_hour > HOUR_MAX) ? '0 : i_cur_hour;
                    min_d   = (i_cur_min  > MIN_MAX)  ? '0 : i_cur_min;
                    sec_d   = (i_cur_sec  > SEC_MAX)  ? '0 : i_cur_sec;
                end
            end
            ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC: begin
                if (i_cancel) begin
                    state_d = ST_RUN;
                end else if (i_mode) begin
                    // Advancing the field drops any same-cycle edit.
                    unique case (state_q)
                        ST_SET_HOUR: state_d = ST_SET_MIN;
                        ST_SET_MIN:  state_d = ST_SET_SEC;
                        default:     state_d = ST_LOAD;
                    endcase
                end else if (do_inc || do_dec) begin
                    unique case (state_q)
                        ST_SET_HOUR: begin
                            if (do_inc) hour_d = (hour_q == HOUR_MAX) ? '0 : hour_q + HOUR_ONE;
                            else        hour_d = (hour_q == '0) ? HOUR_MAX : hour_q - HOUR_ONE;
                        end
                        ST_SET_MIN: begin
                            if (do_inc) min_d = (min_q == MIN_MAX) ? '0 : min_q + MIN_ONE;
                            else        min_d = (min_q == '0) ? MIN_MAX : min_q - MIN_ONE;
                        end
                        default: begin
                            if (do_inc) sec_d = (sec_q == SEC_MAX) ? '0 : sec_q + SEC_ONE;
                            else        sec_d = (sec_q == '0) ? SEC_MAX : sec_q - SEC_ONE;
                        end
                    endcase
                end else if (TO_EN && !btn_any && (to_cnt_q == TO_LAST)) begin
                    // Inactivity auto-cancel: leaves without loading, like i_cancel.
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Idle counter restarts on any button or state change, advances on idle SET cycles.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (btn_any || (state_d != state_q)) begin
            to_cnt_d = '0;
        end else if (TO_EN && in_set) begin
            to_cnt_d = to_cnt_q + TO_ONE;
        end
    end

    always_comb begin
        field_d = 2'd0;
        unique case (state_d)
            ST_SET_HOUR: field_d = 2'd1;
            ST_SET_MIN:  field_d = 2'd2;
            ST_SET_SEC:  field_d = 2'd3;
            default:     field_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            sec_q    <= '0;
            min_q    <= '0;
            hour_q   <= '0;
            to_cnt_q <= '0;
            run_en_q <= 1'b0;
            load_q   <= 1'b0;
            field_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            sec_q    <= sec_d;
            min_q    <= min_d;
            hour_q   <= hour_d;
            to_cnt_q <= to_cnt_d;
            run_en_q <= (state_d == ST_RUN);
            load_q   <= (state_d == ST_LOAD);
            field_q  <= field_d;
        end
    end

    assign o_run_en    = run_en_q;
    assign o_load      = load_q;
    assign o_set_sec   = sec_q;
    assign o_set_min   = min_q;
    assign o_set_hour  = hour_q;
    assign o_set_field = field_q;

endmodule

// File: tb/tb_matbi_watch_set_ctrl.sv
// Bench for matbi_watch_set_ctrl: directed scenarios plus random button traffic.
// Latency: expected outputs are queued per driven cycle and compared just after the next edge.
// Backpressure: not applicable; the DUT accepts a new input set every cycle.
module tb_matbi_watch_set_ctrl;

    localparam int TO_CYC = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_mode = 1'b0, i_inc = 1'b0, i_dec = 1'b0, i_cancel = 1'b0;
    logic [5:0] i_cur_sec = '0, i_cur_min = '0;
    logic [4:0] i_cur_hour = '0;
    logic       o_run_en, o_load;
    logic [5:0] o_set_sec, o_set_min;
    logic [4:0] o_set_hour;
    logic [1:0] o_set_field;

    matbi_watch_set_ctrl #(
        .P_SEC_BIT(6), .P_MIN_BIT(6), .P_HOUR_BIT(5),
        .P_TO_BIT(30), .P_TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk), .reset(reset),
        .i_mode(i_mode), .i_inc(i_inc), .i_dec(i_dec), .i_cancel(i_cancel),
        .i_cur_sec(i_cur_sec), .i_cur_min(i_cur_min), .i_cur_hour(i_cur_hour),
        .o_run_en(o_run_en), .o_load(o_load),
        .o_set_sec(o_set_sec), .o_set_min(o_set_min), .o_set_hour(o_set_hour),
        .o_set_field(o_set_field)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       run_en;
        logic       load;
        logic [5:0] sec;
        logic [5:0] min;
        logic [4:0] hour;
        logic [1:0] field;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   popped = 0;

    // Load observations recorded by the monitor for directed checks.
    int   load_seen = 0;
    int   last_load_h = -1, last_load_m = -1, last_load_s = -1;

    // Reference model: field index (0 = running, 1..3 = editing hour/min/sec, 4 = loading).
    int   m_field = 0;
    int   m_h = 0, m_m = 0, m_s = 0;
    int   m_idle = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int wrap(input int v, input int delta, input int lim);
        return (v + delta + lim) % lim;
    endfunction

    task automatic model(input bit rst, input bit md, input bit inc, input bit dec,
                         input bit cn, input int ch, input int cm, input int cs);
        exp_t e;
        int   nf;
        bit   btn;
        if (rst) begin
            m_field = 0; m_h = 0; m_m = 0; m_s = 0; m_idle = 0;
            e = '0;
        end else begin
            btn = md | inc | dec | cn;
            nf  = m_field;
            if (m_field == 0) begin
                if (md) begin
                    nf  = 1;
                    m_h = (ch > 23) ? 0 : ch;
                    m_m = (cm > 59) ? 0 : cm;
                    m_s = (cs > 59) ? 0 : cs;
                end
            end else if (m_field == 4) begin
                nf = 0;
            end else begin
                if (cn) nf = 0;
                else if (md) nf = m_field + 1;
                else if (inc != dec) begin
                    case (m_field)
                        1: m_h = wrap(m_h, inc ? 1 : -1, 24);
                        2: m_m = wrap(m_m, inc ? 1 : -1, 60);
                        default: m_s = wrap(m_s, inc ? 1 : -1, 60);
                    endcase
                end else if (!btn && (m_idle + 1 == TO_CYC)) nf = 0;
            end
            if (btn || nf != m_field) m_idle = 0;
            else if (m_field >= 1 && m_field <= 3) m_idle++;
            m_field  = nf;
            e.run_en = (nf == 0);
            e.load   = (nf == 4);
            e.field  = (nf >= 1 && nf <= 3) ? 2'(nf) : 2'd0;
            e.hour   = 5'(m_h);
            e.min    = 6'(m_m);
            e.sec    = 6'(m_s);
        end
        exp_q.push_back(e);
        pushed++;
    endtask

    task automatic step(input bit rst, input bit md, input bit inc, input bit dec,
                        input bit cn, input int ch, input int cm, input int cs);
        @(negedge clk);
        reset = rst; i_mode = md; i_inc = inc; i_dec = dec; i_cancel = cn;
        i_cur_hour = 5'(ch); i_cur_min = 6'(cm); i_cur_sec = 6'(cs);
        model(rst, md, inc, dec, cn, ch, cm, cs);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 13, 45, 30);
    endtask

    // Monitor: compare DUT outputs just after every edge against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (o_load === 1'b1) begin
                load_seen++;
                last_load_h = int'(o_set_hour);
                last_load_m = int'(o_set_min);
                last_load_s = int'(o_set_sec);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                popped++;
                chk("run_en", int'(o_run_en), int'(e.run_en));
                chk("load",   int'(o_load),   int'(e.load));
                chk("field",  int'(o_set_field), int'(e.field));
                chk("hour",   int'(o_set_hour),  int'(e.hour));
                chk("min",    int'(o_set_min),   int'(e.min));
                chk("sec",    int'(o_set_sec),   int'(e.sec));
            end
        end
    end

    initial begin
        int loads0;
        int p;
        // Reset, then run.
        repeat (4) step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // Buttons other than mode are ignored while running.
        step(0, 0, 1, 0, 0, 13, 45, 30);
        step(0, 0, 0, 1, 1, 13, 45, 30);

        // Full flow from 13:45:30 -> load 15:44:30.
        loads0 = load_seen;
        step(0, 1, 0, 0, 0, 13, 45, 30);
        step(0, 0, 1, 0, 0, 13, 45, 30);
        step(0, 0, 1, 0, 0, 13, 45, 30);
        step(0, 1, 0, 0, 0, 13, 45, 30);
        step(0, 0, 0, 1, 0, 13, 45, 30);
        step(0, 1, 0, 0, 0, 13, 45, 30);
        step(0, 1, 0, 0, 0, 13, 45, 30);
        idle(3);
        chk("flow_load_count", load_seen - loads0, 1);
        chk("flow_load_hour", last_load_h, 15);
        chk("flow_load_min",  last_load_m, 44);
        chk("flow_load_sec",  last_load_s, 30);

        // Wrap at boundaries, simultaneous inc+dec, then cancel in SET_MIN.
        step(0, 1, 0, 0, 0, 23, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        idle(2);
        // Cancel beats mode in the same cycle.
        step(0, 1, 0, 0, 0, 1, 2, 3);
        step(0, 1, 0, 0, 0, 1, 2, 3);
        step(0, 1, 0, 0, 1, 1, 2, 3);
        idle(2);
        // Out-of-range capture becomes zero; cancel in SET_SEC.
        step(0, 1, 0, 0, 0, 30, 61, 60);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        idle(1);

        // Timeout after 8 idle cycles, then a restart by an inc at cycle 5.
        step(0, 1, 0, 0, 0, 10, 20, 30);
        idle(10);
        step(0, 1, 0, 0, 0, 10, 20, 30);
        idle(4);
        step(0, 0, 1, 0, 0, 10, 20, 30);
        idle(10);

        // Reset mid-edit drops the edit.
        step(0, 1, 0, 0, 0, 5, 6, 7);
        step(0, 0, 1, 0, 0, 5, 6, 7);
        step(1, 0, 0, 0, 0, 5, 6, 7);
        idle(2);

        // Random traffic: busy phase, then sparse phase so timeouts occur.
        for (int n = 0; n < 4000; n++) begin
            p = (n < 2000) ? 4 : 14;
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, p - 1) == 0), ($urandom_range(0, p - 1) == 0),
                 ($urandom_range(0, p - 1) == 0), ($urandom_range(0, 3 * p - 1) == 0),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                 int'($urandom_range(0, 63)));
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("pops_match_pushes", popped, pushed);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
